// File: rtl/data_ram_ws.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_ws
// Description : Wait-state data memory responding on the CPU load/store port.
//               Accepts one request at a time, holds the pipeline with
//               stallreq_o while serving it, and returns a one-cycle ack
//               WAIT_STATES+1 cycles after the accept edge. Big-endian byte
//               lanes (sel[3] = bits 31:24).
// Optional    : define DATA_RAM_ALIGN_CHK_EN to flag illegal sel/addr[1:0]
//               pairs as errors (write suppressed, read data forced to 0).
// Ports       : clk, rst (sync, active high)
//               mem_ce_i, mem_we_i, mem_addr_i[31:0], mem_sel_i[3:0],
//               mem_data_i[31:0]                      - request
//               mem_data_o[31:0], mem_ack_o, mem_err_o - response
//               stallreq_o                             - pipeline stall
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_ws #(
    parameter int ADDR_DEPTH_LOG2 = 10,
    parameter int WAIT_STATES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic        stallreq_o
);

    localparam int         c_DEPTH = 1 << ADDR_DEPTH_LOG2;
    localparam logic [3:0] c_WS    = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic        r_err;

    logic [31:0] r_mem [0:c_DEPTH-1];

    logic                       w_accept;
    logic                       w_go_ack;
    logic                       w_we;
    logic [31:0]                w_addr;
    logic [3:0]                 w_sel;
    logic [31:0]                w_wdata;
    logic [ADDR_DEPTH_LOG2-1:0] w_idx;
    logic                       w_oor;
    logic                       w_align_err;
    logic                       w_err;
    logic                       w_commit;

    assign w_accept = (r_state == S_IDLE) && mem_ce_i;

    // The edge entering ACK either is the accept edge itself (zero wait
    // states) or the last WAIT edge with the counter at 1.
    assign w_go_ack = (w_accept && (c_WS == 4'd0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // With zero wait states the commit happens on the accept edge, before
    // the latched copy exists, so the live inputs are used while in IDLE.
    assign w_we    = (r_state == S_IDLE) ? mem_we_i   : r_we;
    assign w_addr  = (r_state == S_IDLE) ? mem_addr_i : r_addr;
    assign w_sel   = (r_state == S_IDLE) ? mem_sel_i  : r_sel;
    assign w_wdata = (r_state == S_IDLE) ? mem_data_i : r_wdata;

    assign w_idx = w_addr[ADDR_DEPTH_LOG2+1:2];
    assign w_oor = |(w_addr >> (ADDR_DEPTH_LOG2 + 2));

`ifdef DATA_RAM_ALIGN_CHK_EN
    always_comb begin
        w_align_err = 1'b1;
        case ({w_sel, w_addr[1:0]})
            {4'b1111, 2'b00},
            {4'b1100, 2'b00},
            {4'b0011, 2'b10},
            {4'b1000, 2'b00},
            {4'b0100, 2'b01},
            {4'b0010, 2'b10},
            {4'b0001, 2'b11}: w_align_err = 1'b0;
            default:          w_align_err = 1'b1;
        endcase
    end
`else
    // Byte offset is irrelevant without alignment checking.
    logic w_unused_lsb;
    assign w_unused_lsb = ^w_addr[1:0];
    assign w_align_err  = 1'b0;
`endif

    assign w_err    = w_oor || w_align_err;
    assign w_commit = w_go_ack && w_we && !w_err && !rst;

    // Control path and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_sel   <= 4'd0;
            r_wdata <= 32'd0;
            r_data  <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_data <= 32'd0;
            r_err  <= 1'b0;
            if (w_go_ack) begin
                r_data <= w_err ? 32'd0 : r_mem[w_idx];
                r_err  <= w_err;
            end
            case (r_state)
                S_IDLE: begin
                    if (mem_ce_i) begin
                        r_we    <= mem_we_i;
                        r_addr  <= mem_addr_i;
                        r_sel   <= mem_sel_i;
                        r_wdata <= mem_data_i;
                        r_cnt   <= c_WS;
                        r_state <= (c_WS == 4'd0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage array: never reset, byte-lane write enables.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_sel[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    assign mem_data_o = r_data;
    assign mem_ack_o  = (r_state == S_ACK);
    assign mem_err_o  = r_err;
    assign stallreq_o = w_accept || (r_state == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_data_ram_ws.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_ws
// Description : Self-checking bench for data_ram_ws. Two instances: one with
//               WAIT_STATES=2 / 1024 words, one with WAIT_STATES=0 / 16 words
//               driven back-to-back. Directed scenarios plus random traffic
//               checked against a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_ws;

    localparam int AW  = 10;
    localparam int WS  = 2;
    localparam int ZAW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ce, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    logic        ack, err, stall;

    logic        z_ce, z_we;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [3:0]  z_sel;
    logic        z_ack, z_err, z_stall;

    data_ram_ws #(.ADDR_DEPTH_LOG2(AW), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr), .mem_sel_i(sel),
        .mem_data_i(wdata), .mem_data_o(rdata), .mem_ack_o(ack),
        .mem_err_o(err), .stallreq_o(stall)
    );

    data_ram_ws #(.ADDR_DEPTH_LOG2(ZAW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .mem_ce_i(z_ce), .mem_we_i(z_we), .mem_addr_i(z_addr), .mem_sel_i(z_sel),
        .mem_data_i(z_wdata), .mem_data_o(z_rdata), .mem_ack_o(z_ack),
        .mem_err_o(z_err), .stallreq_o(z_stall)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: plain word arrays plus "contents known" flags.
    logic [31:0] m_mem [0:(1<<AW)-1];
    bit          m_val [0:(1<<AW)-1];
    logic [31:0] zm_mem [0:(1<<ZAW)-1];
    bit          zm_val [0:(1<<ZAW)-1];

    logic [3:0] lsel [7] = '{4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [1:0] llo  [7] = '{2'b00,   2'b00,   2'b10,   2'b00,   2'b01,   2'b10,   2'b11};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit pair_ok(input logic [3:0] s, input logic [1:0] lo);
`ifdef DATA_RAM_ALIGN_CHK_EN
        for (int i = 0; i < 7; i++) begin
            if (s == lsel[i] && lo == llo[i]) return 1'b1;
        end
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    // Random request generator shared by both instances.
    task automatic gen(input int aw, output logic w, output logic [31:0] a,
                       output logic [3:0] s, output logic [31:0] d);
        int r, p;
        logic [1:0] lo;
        r = int'($urandom % 20);
        if (($urandom % 4) != 0) begin
            p  = int'($urandom % 7);
            s  = lsel[p];
            lo = llo[p];
        end else begin
            s  = 4'($urandom);
            lo = 2'($urandom);
        end
        if (r < 13)      a = {26'd0, 4'($urandom), lo};
        else if (r < 17) a = 32'(($urandom % (1 << aw)) << 2) | {30'd0, lo};
        else             a = $urandom | (32'd1 << (aw + 2 + int'($urandom % (30 - aw))));
        w = 1'($urandom);
        d = $urandom;
    endtask

    // One complete access on the WAIT_STATES=2 instance, checked against the model.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd, output logic e);
        logic   exp_err;
        int     idx, cyc;
        exp_err = ((a >> (AW + 2)) != 0) || !pair_ok(s, a[1:0]);
        idx     = int'((a >> 2) & ((1 << AW) - 1));
        @(negedge clk);
        ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
        #1 chk("stall_req", {31'd0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Inputs are scrambled after accept; the request must already be latched.
        ce = 1'b0; we = 1'($urandom); addr = $urandom; sel = 4'($urandom); wdata = $urandom;
        cyc = 1;
        while (ack !== 1'b1 && cyc < 20) begin
            chk("stall_wait", {31'd0, stall}, 32'd1);
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(WS + 1));
        chk("stall_ack", {31'd0, stall}, 32'd0);
        chk("err", {31'd0, err}, {31'd0, exp_err});
        if (!w) begin
            if (exp_err)          chk("rdata_err", rdata, 32'd0);
            else if (m_val[idx])  chk("rdata", rdata, m_mem[idx]);
        end
        if (w && !exp_err) begin
            if (m_val[idx]) m_mem[idx] = merge(m_mem[idx], d, s);
            else if (s == 4'hF) begin m_mem[idx] = d; m_val[idx] = 1'b1; end
        end
        rd = rdata;
        e  = err;
        @(negedge clk);
        chk("ack_pulse", {31'd0, ack}, 32'd0);
        chk("rdata_idle", rdata, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, a, d;
        logic        e, w, zexp_err;
        logic [3:0]  s;
        int          zidx;

        rst = 1'b1;
        ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'd0; wdata = 32'd0;
        z_ce = 1'b0; z_we = 1'b0; z_addr = 32'd0; z_sel = 4'd0; z_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_data", rdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_z_ack", {31'd0, z_ack}, 32'd0);
        rst = 1'b0;

        // Full word write / read.
        do_req(1'b1, 32'h10, 4'hF, 32'h1234_5678, rd, e);
        chk("t1_werr", {31'd0, e}, 32'd0);
        do_req(1'b0, 32'h10, 4'hF, 32'd0, rd, e);
        chk("t1_rd", rd, 32'h1234_5678);
        chk("t1_rerr", {31'd0, e}, 32'd0);

        // Single byte lane (bits 23:16).
        do_req(1'b1, 32'h11, 4'b0100, 32'h00AB_0000, rd, e);
        do_req(1'b0, 32'h10, 4'hF, 32'd0, rd, e);
        chk("t2_rd", rd, 32'h12AB_5678);

        // Out of range and the last valid word.
        do_req(1'b1, 32'h0, 4'hF, 32'hA5A5_0001, rd, e);
        do_req(1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, rd, e);
        chk("t3_werr", {31'd0, e}, 32'd1);
        do_req(1'b0, 32'h0, 4'hF, 32'd0, rd, e);
        chk("t3_w0", rd, 32'hA5A5_0001);
        do_req(1'b0, 32'h0001_0000, 4'hF, 32'd0, rd, e);
        chk("t3_rd", rd, 32'd0);
        chk("t3_rerr", {31'd0, e}, 32'd1);
        do_req(1'b1, 32'hFFC, 4'hF, 32'hCAFE_0FFC, rd, e);
        do_req(1'b0, 32'hFFC, 4'hF, 32'd0, rd, e);
        chk("t3_top", rd, 32'hCAFE_0FFC);
        chk("t3_toperr", {31'd0, e}, 32'd0);
        do_req(1'b0, 32'h1000, 4'hF, 32'd0, rd, e);
        chk("t3_edge_err", {31'd0, e}, 32'd1);

        // Reset during WAIT drops the write.
        do_req(1'b1, 32'h20, 4'hF, 32'h0BAD_F00D, rd, e);
        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_ack", {31'd0, ack}, 32'd0);
        chk("t4_err", {31'd0, err}, 32'd0);
        chk("t4_data", rdata, 32'd0);
        chk("t4_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t4_noack", {31'd0, ack}, 32'd0);
        end
        do_req(1'b0, 32'h20, 4'hF, 32'd0, rd, e);
        chk("t4_rd", rd, 32'h0BAD_F00D);

        // Alignment behaviour.
`ifdef DATA_RAM_ALIGN_CHK_EN
        do_req(1'b1, 32'h12, 4'hF, 32'h1111_1111, rd, e);
        chk("t6_misalign_err", {31'd0, e}, 32'd1);
        do_req(1'b1, 32'h13, 4'b0001, 32'h0000_00C3, rd, e);
        chk("t6_byte_err", {31'd0, e}, 32'd0);
        do_req(1'b0, 32'h10, 4'hF, 32'd0, rd, e);
        chk("t6_rd", rd, 32'h12AB_56C3);
        do_req(1'b0, 32'h10, 4'b0000, 32'd0, rd, e);
        chk("t6_sel0_err", {31'd0, e}, 32'd1);
`else
        do_req(1'b1, 32'h12, 4'hF, 32'h1111_1111, rd, e);
        chk("t6_noalign_err", {31'd0, e}, 32'd0);
        do_req(1'b0, 32'h10, 4'hF, 32'd0, rd, e);
        chk("t6_rd", rd, 32'h1111_1111);
`endif

        // Random traffic on the wait-state instance.
        for (int i = 0; i < 200; i++) begin
            gen(AW, w, a, s, d);
            do_req(w, a, s, d, rd, e);
        end

        // Zero-wait-state instance, mem_ce_i held high throughout.
        @(negedge clk);
        z_ce = 1'b1;
        z_we = 1'b1; z_addr = 32'd0; z_sel = 4'hF; z_wdata = $urandom;
        for (int i = 0; i < 60; i++) begin
            zexp_err = ((z_addr >> (ZAW + 2)) != 0) || !pair_ok(z_sel, z_addr[1:0]);
            zidx     = int'((z_addr >> 2) & ((1 << ZAW) - 1));
            @(posedge clk);
            @(negedge clk);
            chk("z_ack", {31'd0, z_ack}, 32'd1);
            chk("z_err", {31'd0, z_err}, {31'd0, zexp_err});
            chk("z_stall_ack", {31'd0, z_stall}, 32'd0);
            if (!z_we) begin
                if (zexp_err)          chk("z_rdata_err", z_rdata, 32'd0);
                else if (zm_val[zidx]) chk("z_rdata", z_rdata, zm_mem[zidx]);
            end
            if (z_we && !zexp_err) begin
                if (zm_val[zidx]) zm_mem[zidx] = merge(zm_mem[zidx], z_wdata, z_sel);
                else if (z_sel == 4'hF) begin zm_mem[zidx] = z_wdata; zm_val[zidx] = 1'b1; end
            end
            // Next request is presented during ACK; it must not be taken until IDLE.
            if (i < 15) begin
                z_we = 1'b1; z_addr = 32'((i + 1) * 4); z_sel = 4'hF; z_wdata = $urandom;
            end else begin
                gen(ZAW, w, a, s, d);
                z_we = w; z_addr = a; z_sel = s; z_wdata = d;
            end
            @(posedge clk);
            @(negedge clk);
            chk("z_idle_ack", {31'd0, z_ack}, 32'd0);
            chk("z_idle_stall", {31'd0, z_stall}, 32'd1);
            chk("z_idle_data", z_rdata, 32'd0);
        end
        z_ce = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
